calc_port_scheduler: RTL and testbench

- Front end for the calculator datapath. Accepts requests from NUM_PORTS independent requester ports and queues one outstanding operation per port.
- Grants pending operations round-robin to a single shared ALU stage (add/sub/shift). Returns each result on the originating port's out_data/out_resp.
- Replaces per-port ALUs. Requester-facing protocol is the calculator's cmd/data two-beat protocol.

---
 rtl/calc_port_scheduler_if.sv | 24 ++
 rtl/calc_port_scheduler.sv | 165 ++++++++++++++++
 tb/tb_calc_port_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_port_scheduler_if.sv
// Requester-facing bundle for calc_port_scheduler: flattened per-port
// cmd/data request lanes and per-port result/response/busy lanes.
interface calc_port_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMD_WIDTH  = 4,
  parameter int unsigned RESP_WIDTH = 2,
  parameter int unsigned NUM_PORTS  = 4
);
  logic [NUM_PORTS*CMD_WIDTH-1:0]  req_cmd_in;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data_in;
  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
  logic [NUM_PORTS*RESP_WIDTH-1:0] out_resp;
  logic [NUM_PORTS-1:0]            port_busy;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_data, out_resp, port_busy
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_data, out_resp, port_busy
  );
endinterface

// File: rtl/calc_port_scheduler.sv
// Multi-port front end: per-port cmd/op1/op2 capture, round-robin grant of
// pending ops to one shared add/sub/shift stage, one-cycle registered responses.
module calc_port_scheduler #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CMD_WIDTH   = 4,
  parameter int unsigned RESP_WIDTH  = 2,
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input logic clk,
  input logic rst,
  calc_port_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [CMD_WIDTH-1:0]  CMD_NOP  = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0]  CMD_ADD  = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0]  CMD_SUB  = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0]  CMD_SHL  = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0]  CMD_SHR  = CMD_WIDTH'(6);
  localparam logic [RESP_WIDTH-1:0] RESP_OK  = RESP_WIDTH'(1);
  localparam logic [RESP_WIDTH-1:0] RESP_ERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, WAIT_OP2, PENDING} port_state_t;

  port_state_t           state_q [NUM_PORTS];
  port_state_t           state_d [NUM_PORTS];
  logic [CMD_WIDTH-1:0]  cmd_q   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] op1_q   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] op2_q   [NUM_PORTS];

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_vld;

  logic [CMD_WIDTH-1:0]  g_cmd;
  logic [DATA_WIDTH-1:0] g_op1;
  logic [DATA_WIDTH-1:0] g_op2;
  logic [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH-1:0] alu_data;
  logic [RESP_WIDTH-1:0] alu_resp;

  logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_q;
  logic [NUM_PORTS*RESP_WIDTH-1:0] out_resp_q;

  // Search begins one past the last granted port; a port only counts once its
  // PENDING state is registered, so it cannot win in the cycle it arrives.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = (32'(ptr_q) + i) % NUM_PORTS;
      if (!grant_vld && state_q[idx] == PENDING) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      state_d[p] = state_q[p];
      unique case (state_q[p])
        IDLE:     if (bus.req_cmd_in[p*CMD_WIDTH +: CMD_WIDTH] != CMD_NOP) state_d[p] = WAIT_OP2;
        WAIT_OP2: state_d[p] = PENDING;
        PENDING:  if (grant_vld && grant_idx == PTR_W'(p)) state_d[p] = IDLE;
        default:  state_d[p] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= IDLE;
        cmd_q[p]   <= '0;
        op1_q[p]   <= '0;
        op2_q[p]   <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
        if (state_q[p] == IDLE && bus.req_cmd_in[p*CMD_WIDTH +: CMD_WIDTH] != CMD_NOP) begin
          cmd_q[p] <= bus.req_cmd_in[p*CMD_WIDTH +: CMD_WIDTH];
          op1_q[p] <= bus.req_data_in[p*DATA_WIDTH +: DATA_WIDTH];
        end
        if (state_q[p] == WAIT_OP2) begin
          op2_q[p] <= bus.req_data_in[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_W'(NUM_PORTS - 1);
    end else if (grant_vld) begin
      ptr_q <= grant_idx;
    end
  end

  always_comb begin
    g_cmd    = cmd_q[grant_idx];
    g_op1    = op1_q[grant_idx];
    g_op2    = op2_q[grant_idx];
    wide     = '0;
    alu_data = '0;
    alu_resp = RESP_ERR;
    unique case (g_cmd)
      CMD_ADD: begin
        wide = {1'b0, g_op1} + {1'b0, g_op2};
        if (!wide[DATA_WIDTH]) begin
          alu_data = wide[DATA_WIDTH-1:0];
          alu_resp = RESP_OK;
        end
      end
      CMD_SUB: begin
        if (g_op2 <= g_op1) begin
          alu_data = g_op1 - g_op2;
          alu_resp = RESP_OK;
        end
      end
      CMD_SHL: begin
        alu_data = g_op1 << g_op2[SHAMT_WIDTH-1:0];
        alu_resp = RESP_OK;
      end
      CMD_SHR: begin
        alu_data = g_op1 >> g_op2[SHAMT_WIDTH-1:0];
        alu_resp = RESP_OK;
      end
      default: begin
        alu_data = '0;
        alu_resp = RESP_ERR;
      end
    endcase
  end

  // Responses live for exactly one cycle: every lane clears unless granted now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
      out_resp_q <= '0;
    end else begin
      out_data_q <= '0;
      out_resp_q <= '0;
      if (grant_vld) begin
        out_data_q[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] <= alu_data;
        out_resp_q[32'(grant_idx)*RESP_WIDTH +: RESP_WIDTH] <= alu_resp;
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bus.port_busy[p] = (state_q[p] != IDLE);
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_resp = out_resp_q;

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Self-checking bench for calc_port_scheduler: directed test-plan steps then
// random traffic, all compared every cycle against a per-port behavioural model.
module tb_calc_port_scheduler;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [3:0]  cmd_drv  [NP];
  logic [31:0] data_drv [NP];

  // Model: phase 0 idle, 1 awaiting operand2, 2 queued for the ALU.
  int          ph   [NP];
  logic [3:0]  mcmd [NP];
  logic [31:0] mop1 [NP];
  logic [31:0] mop2 [NP];
  int          ptr;

  calc_port_scheduler_if #(.DATA_WIDTH(32), .CMD_WIDTH(4), .RESP_WIDTH(2), .NUM_PORTS(NP)) bus ();

  calc_port_scheduler #(
    .DATA_WIDTH(32), .CMD_WIDTH(4), .RESP_WIDTH(2), .NUM_PORTS(NP), .SHAMT_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.req_cmd_in  = '0;
    bus.req_data_in = '0;
    for (int p = 0; p < NP; p++) begin
      bus.req_cmd_in[p*4 +: 4]   = cmd_drv[p];
      bus.req_data_in[p*32 +: 32] = data_drv[p];
    end
  end

  function automatic logic [1:0] resp_of(int p);
    return bus.out_resp[p*2 +: 2];
  endfunction

  function automatic logic [31:0] data_of(int p);
    return bus.out_data[p*32 +: 32];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] r, output logic [31:0] d);
    longint unsigned s;
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = 32'(s); end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << (b % 32); end
      4'd6: begin r = 2'd1; d = a >> (b % 32); end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      ph[p] = 0; mcmd[p] = '0; mop1[p] = '0; mop2[p] = '0;
    end
    ptr = NP - 1;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < NP; p++) begin
      cmd_drv[p]  = '0;
      data_drv[p] = '0;
    end
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
    cmd_drv[p]  = c;
    data_drv[p] = d;
  endtask

  // One clock: predict from current inputs, clock, then compare every lane.
  task automatic step();
    int          g;
    logic [1:0]  er [NP];
    logic [31:0] ed [NP];
    logic [1:0]  r;
    logic [31:0] d;
    g = -1;
    for (int k = 1; k <= NP; k++) begin
      int idx;
      idx = (ptr + k) % NP;
      if (g < 0 && ph[idx] == 2) g = idx;
    end
    for (int p = 0; p < NP; p++) begin er[p] = 2'd0; ed[p] = 32'd0; end
    if (g >= 0) begin
      ref_alu(mcmd[g], mop1[g], mop2[g], r, d);
      er[g] = r;
      ed[g] = d;
      ptr   = g;
    end
    for (int p = 0; p < NP; p++) begin
      if (ph[p] == 0) begin
        if (cmd_drv[p] != 4'd0) begin ph[p] = 1; mcmd[p] = cmd_drv[p]; mop1[p] = data_drv[p]; end
      end else if (ph[p] == 1) begin
        mop2[p] = data_drv[p];
        ph[p]   = 2;
      end else if (g == p) begin
        ph[p] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      check($sformatf("resp_p%0d", p), 32'(resp_of(p)), 32'(er[p]));
      check($sformatf("data_p%0d", p), data_of(p), ed[p]);
      check($sformatf("busy_p%0d", p), 32'(bus.port_busy[p]), 32'(ph[p] != 0));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_resp", 32'(bus.out_resp), 32'd0);
    check("rst_busy", 32'(bus.port_busy), 32'd0);
    rst = 1'b0;
  endtask

  // Isolated operation on one port: response expected after the third edge.
  task automatic run_op(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] exp_r, input logic [31:0] exp_d);
    set_port(p, c, a);
    step();
    set_port(p, 4'd0, b);
    step();
    clear_inputs();
    step();
    check($sformatf("op_resp_p%0d", p), 32'(resp_of(p)), 32'(exp_r));
    check($sformatf("op_data_p%0d", p), data_of(p), exp_d);
    step();
  endtask

  task automatic expect_only(input int p, input logic [31:0] exp_d);
    check($sformatf("fair_resp_p%0d", p), 32'(resp_of(p)), 32'd1);
    check($sformatf("fair_data_p%0d", p), data_of(p), exp_d);
  endtask

  initial begin
    int          p2_resp_count;
    logic [31:0] p2_data;
    logic [3:0]  cmd_tab [8];
    logic [31:0] edge_tab [6];
    clear_inputs();
    model_reset();
    do_reset();

    run_op(0, 4'd1, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h8);
    run_op(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
    run_op(2, 4'd2, 32'h0000_0003, 32'h0000_0005, 2'd2, 32'h0);
    run_op(3, 4'd4, 32'h0000_0011, 32'h0000_0022, 2'd2, 32'h0);
    run_op(0, 4'd5, 32'h0000_0001, 32'h0000_0002, 2'd1, 32'h4);
    run_op(0, 4'd6, 32'h8000_0000, 32'h0000_0021, 2'd1, 32'h4000_0000);

    // Fairness from reset, then an immediate repeat continuing from pointer 3.
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int p = 0; p < NP; p++) set_port(p, 4'd1, 32'(p));
      step();
      for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd10);
      step();
      clear_inputs();
      for (int p = 0; p < NP; p++) begin
        step();
        expect_only(p, 32'(10 + p));
      end
    end
    step();

    // Second command on a busy port is dropped.
    for (int p = 0; p < NP; p++) set_port(p, 4'd1, 32'(p));
    set_port(2, 4'd2, 32'd9);
    step();
    for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd1);
    set_port(2, 4'd1, 32'd4);
    step();
    clear_inputs();
    set_port(2, 4'd1, 32'd77);
    p2_resp_count = 0;
    p2_data       = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      clear_inputs();
      if (resp_of(2) != 2'd0) begin
        p2_resp_count++;
        p2_data = data_of(2);
        check("busy2_at_resp", 32'(bus.port_busy[2]), 32'd0);
      end else if (p2_resp_count == 0) begin
        check("busy2_waiting", 32'(bus.port_busy[2]), 32'd1);
      end
    end
    check("p2_resp_count", 32'(p2_resp_count), 32'd1);
    check("p2_sub_data", p2_data, 32'd5);

    // Reset with one response on the wire and the rest pending.
    for (int p = 0; p < NP; p++) set_port(p, 4'd1, 32'(p + 1));
    step();
    for (int p = 0; p < NP; p++) set_port(p, 4'd0, 32'd3);
    step();
    clear_inputs();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_resp", 32'(bus.out_resp), 32'd0);
    check("async_rst_data", bus.out_data[31:0] | bus.out_data[63:32] | bus.out_data[95:64] | bus.out_data[127:96], 32'd0);
    check("async_rst_busy", 32'(bus.port_busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) step();
    run_op(3, 4'd1, 32'd1, 32'd1, 2'd1, 32'd2);

    // Random traffic across all ports.
    cmd_tab  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd7, 4'd15};
    edge_tab = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_001F};
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(2) == 0) cmd_drv[p] = cmd_tab[$urandom_range(7)];
        else cmd_drv[p] = 4'd0;
        if ($urandom_range(3) == 0) data_drv[p] = edge_tab[$urandom_range(5)];
        else data_drv[p] = $urandom;
      end
      step();
    end
    clear_inputs();
    for (int cyc = 0; cyc < 8; cyc++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
